rgb2grey_frame_ctrl: RTL and testbench

Frame-level sequencer for the shift-add RGB-to-grey converter. On a start pulse it accepts exactly FRAME_W x FRAME_H packed 24-bit pixels over a valid/ready stream and passes each through the combinational converter. It registers each grey result and tags it with line and frame markers. It signals done or aborted, and sits between the pixel source (DMA/line buffer) and the grey-frame sink.

---
 rtl/rgb2grey_pkg.sv | 10 +
 rtl/rgb2grey_frame_ctrl_grey_shift_add.sv | 15 +
 rtl/rgb2grey_frame_ctrl.sv | 101 ++++++++++
 tb/tb_rgb2grey_frame_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2grey_pkg.sv
// rgb2grey_pkg: shared state encoding, pixel widths and channel slices for the grey frame controller
package rgb2grey_pkg;
  localparam int PIX_W = 24;
  localparam int GREY_W = 8;
  localparam int CH_W = 8;
  localparam int P0_LO = 0;
  localparam int P1_LO = 8;
  localparam int P2_LO = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/rgb2grey_frame_ctrl_grey_shift_add.sv
// grey_shift_add: combinational shift-add RGB to grey converter (max 244, never wraps)
module grey_shift_add
  import rgb2grey_pkg::*;
(
  input  logic [PIX_W-1:0]  rgb,
  output logic [GREY_W-1:0] grey
);
  logic [CH_W-1:0] p0, p1, p2;
  assign p0 = rgb[P0_LO +: CH_W];
  assign p1 = rgb[P1_LO +: CH_W];
  assign p2 = rgb[P2_LO +: CH_W];
  assign grey = (p2 >> 2) + (p2 >> 5) + (p2 >> 6)
              + (p1 >> 1) + (p1 >> 4) + (p1 >> 6) + (p1 >> 7)
              + (p0 >> 4) + (p0 >> 5) + (p0 >> 6);
endmodule

// File: rtl/rgb2grey_frame_ctrl.sv
// rgb2grey_frame_ctrl: frame sequencer streaming FRAME_W x FRAME_H pixels to grey with line/frame markers; LUMA_STATS_EN adds min/max luma
module rgb2grey_frame_ctrl
  import rgb2grey_pkg::*;
#(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int XW = $clog2(FRAME_W),
  parameter int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_rgb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [GREY_W-1:0] m_grey,
  output logic              m_sol,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef LUMA_STATS_EN
  ,
  output logic [GREY_W-1:0] luma_min,
  output logic [GREY_W-1:0] luma_max
`endif
);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
  state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [GREY_W-1:0] grey;
  logic kill, accept, last;
  grey_shift_add u_conv (.rgb(s_rgb), .grey(grey));
  assign kill = abort && (state == RUN || state == DRAIN);
  assign s_ready = state == RUN && !abort && (!m_valid || m_ready);
  assign accept = s_valid && s_ready;
  assign last = x == X_LAST && y == Y_LAST;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = kill ? IDLE :
               state == IDLE  ? (start ? RUN : IDLE) :
               state == RUN   ? (accept && last ? DRAIN : RUN) :
               state == DRAIN ? (!m_valid || m_ready ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      aborted <= 1'b0;
    end else begin
      state <= state_nx;
      aborted <= kill;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      m_valid <= 1'b0;
      m_grey <= '0;
      m_sol <= 1'b0;
      m_eol <= 1'b0;
      m_eof <= 1'b0;
    end else if (kill) begin
      x <= '0;
      y <= '0;
      m_valid <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_grey <= grey;
      m_sol <= x == '0;
      m_eol <= x == X_LAST;
      m_eof <= last;
      x <= x == X_LAST ? '0 : x + 1'b1;
      if (x == X_LAST) y <= y == Y_LAST ? '0 : y + 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
`ifdef LUMA_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luma_min <= '1;
      luma_max <= '0;
    end else if (state == IDLE && start) begin
      luma_min <= '1;
      luma_max <= '0;
    end else if (m_valid && m_ready) begin
      if (m_grey < luma_min) luma_min <= m_grey;
      if (m_grey > luma_max) luma_max <= m_grey;
    end
  end
`endif
endmodule

// File: tb/tb_rgb2grey_frame_ctrl.sv
// tb_rgb2grey_frame_ctrl: directed self-checking bench for a 4x2 frame
module tb_rgb2grey_frame_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic [23:0] s_rgb = '0;
  logic s_ready, m_valid, m_sol, m_eol, m_eof, busy, done, aborted;
  logic [7:0] m_grey;
`ifdef LUMA_STATS_EN
  logic [7:0] luma_min, luma_max;
`endif
  int total = 0, passed = 0;
  logic [23:0] pix [8] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00,
                           24'h0000FF, 24'h808080, 24'h000000, 24'h000000};
  logic [7:0] exp_g [8] = '{8'd244, 8'd0, 8'd73, 8'd146, 8'd25, 8'd127, 8'd0, 8'd0};

  rgb2grey_frame_ctrl #(.FRAME_W(4), .FRAME_H(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb),
    .m_valid(m_valid), .m_ready(m_ready), .m_grey(m_grey),
    .m_sol(m_sol), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef LUMA_STATS_EN
    , .luma_min(luma_min), .luma_max(luma_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    total++;
    if ({m_valid, m_grey, m_sol, m_eol, m_eof, busy, done, aborted, s_ready} !== 16'h0)
      $display("FAIL reset outputs got=%h want=0",
               {m_valid, m_grey, m_sol, m_eol, m_eof, busy, done, aborted, s_ready});
    else passed++;
    tick;
    rst_n = 1'b1;
    tick;
    total++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset busy=%b want=0", busy);
    else passed++;
  endtask

  task automatic run_frame(input bit mid_start);
    m_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_rgb = pix[i];
      start = mid_start && i == 2;
      #1;
      total++;
      if (s_ready !== 1'b1) $display("FAIL s_ready_run px=%0d got=%b want=1", i, s_ready);
      else passed++;
      tick;
      total++;
      if ({m_valid, m_grey, m_sol, m_eol, m_eof} !== {1'b1, exp_g[i], i % 4 == 0, i % 4 == 3, i == 7})
        $display("FAIL out px=%0d got v=%b g=%0d sol=%b eol=%b eof=%b want g=%0d",
                 i, m_valid, m_grey, m_sol, m_eol, m_eof, exp_g[i]);
      else passed++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    total++;
    if (done !== 1'b0) $display("FAIL done_early got=%b want=0", done);
    else passed++;
    tick;
    total++;
    if ({done, busy, m_valid} !== 3'b110) $display("FAIL done_pulse got done/busy/valid=%b want=110", {done, busy, m_valid});
    else passed++;
    tick;
    total++;
    if ({done, busy} !== 2'b00) $display("FAIL done_end got done/busy=%b want=00", {done, busy});
    else passed++;
  endtask

  task automatic test_stall;
    int n_in, n_out;
    bit stalled, got_done;
    logic [11:0] held;
    n_in = 0;
    n_out = 0;
    stalled = 0;
    got_done = 0;
    held = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 80 && !got_done; c++) begin
      m_ready = (c % 2) == 0;
      s_valid = n_in < 8;
      s_rgb = n_in < 8 ? pix[n_in] : 24'h0;
      #1;
      if (stalled) begin
        total++;
        if ({m_valid, m_grey, m_sol, m_eol, m_eof} !== held)
          $display("FAIL stall_hold got=%h want=%h", {m_valid, m_grey, m_sol, m_eol, m_eof}, held);
        else passed++;
      end
      if (m_valid && !m_ready) begin
        total++;
        if (s_ready !== 1'b0) $display("FAIL stall_s_ready got=%b want=0", s_ready);
        else passed++;
      end
      if (m_valid && m_ready) begin
        total++;
        if (n_out >= 8) $display("FAIL stall_extra_out got=%0d want<8", n_out);
        else if ({m_grey, m_sol, m_eol, m_eof} !== {exp_g[n_out], n_out % 4 == 0, n_out % 4 == 3, n_out == 7})
          $display("FAIL stall_out idx=%0d got g=%0d sol=%b eol=%b eof=%b want g=%0d",
                   n_out, m_grey, m_sol, m_eol, m_eof, exp_g[n_out]);
        else passed++;
      end
      if (done) got_done = 1;
      stalled = m_valid && !m_ready;
      held = {m_valid, m_grey, m_sol, m_eol, m_eof};
      if (s_valid && s_ready) n_in++;
      if (m_valid && m_ready) n_out++;
      if (!got_done) tick;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    total++;
    if (!got_done || n_in != 8 || n_out != 8)
      $display("FAIL stall_counts got done=%0d in=%0d out=%0d want 1/8/8", got_done, n_in, n_out);
    else passed++;
    tick;
    tick;
  endtask

  task automatic test_abort;
    m_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_rgb = pix[i];
      tick;
    end
    s_rgb = pix[3];
    abort = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b0) $display("FAIL abort_s_ready got=%b want=0", s_ready);
    else passed++;
    tick;
    abort = 1'b0;
    s_valid = 1'b0;
    total++;
    if ({aborted, m_valid, busy, done} !== 4'b1000)
      $display("FAIL abort_pulse got ab/v/busy/done=%b want=1000", {aborted, m_valid, busy, done});
    else passed++;
    tick;
    total++;
    if ({aborted, done} !== 2'b00) $display("FAIL abort_end got ab/done=%b want=00", {aborted, done});
    else passed++;
    run_frame(0);
  endtask

  task automatic test_async_reset;
    m_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    s_valid = 1'b1;
    s_rgb = pix[0];
    tick;
    s_valid = 1'b0;
    total++;
    if ({m_valid, busy} !== 2'b11) $display("FAIL pre_reset got v/busy=%b want=11", {m_valid, busy});
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_valid, busy, s_ready} !== 3'b000) $display("FAIL async_reset got v/busy/rdy=%b want=000", {m_valid, busy, s_ready});
    else passed++;
    tick;
    rst_n = 1'b1;
    tick;
    run_frame(0);
  endtask

`ifdef LUMA_STATS_EN
  task automatic test_luma_stats;
    int waited;
    m_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_rgb = i == 7 ? 24'hFFFFFF : 24'h808080;
      tick;
    end
    s_valid = 1'b0;
    waited = 0;
    while (!done && waited < 20) begin
      tick;
      waited++;
    end
    total++;
    if (!done || luma_min !== 8'd127 || luma_max !== 8'd244)
      $display("FAIL luma_stats got done=%b min=%0d max=%0d want 1/127/244", done, luma_min, luma_max);
    else passed++;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    run_frame(0);
    test_stall;
    test_abort;
    run_frame(1);
    test_async_reset;
`ifdef LUMA_STATS_EN
    test_luma_stats;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
